// File: rtl/axi_mem_if_pkg.sv
// Shared types for the AXI-to-memory interface blocks.
//   resp_t     : AXI response codes (BRESP/RRESP)
//   burst_t    : AXI burst types (11 is reserved and has no member)
//   wr_state_t : write-controller FSM states
//   axi_aw_is_err : classifies an AW request as unsupported
package axi_mem_if_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_DATA  = 2'b01,
      ST_DRAIN = 2'b10,
      ST_RESP  = 2'b11
   } wr_state_t;

   // Reserved burst type, beat wider than the bus, or a WRAP length the
   // protocol does not allow.
   function automatic logic axi_aw_is_err(input logic [1:0]  burst,
                                          input logic [2:0]  size,
                                          input logic [7:0]  len,
                                          input int unsigned nb_log2);
      logic bad_wrap;
      bad_wrap = (burst == BURST_WRAP) &&
                 !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
      return (burst == 2'b11) || (32'(size) > nb_log2) || bad_wrap;
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address generator.
//   addr      : current beat byte address
//   size      : log2 bytes per beat
//   len       : beats minus 1 (sets the WRAP span)
//   burst     : FIXED / INCR / WRAP
//   next_addr : byte address of the following beat
module axi_burst_addr_gen
   import axi_mem_if_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [2:0]            size,
   input  logic [7:0]            len,
   input  logic [1:0]            burst,
   output logic [ADDR_WIDTH-1:0] next_addr
);

   logic [ADDR_WIDTH-1:0] incr;
   logic [ADDR_WIDTH-1:0] span;
   logic [ADDR_WIDTH-1:0] incr_next;
   logic [ADDR_WIDTH-1:0] wrap_next;

   always_comb begin
      incr      = ADDR_WIDTH'(1) << size;
      span      = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
      // INCR re-aligns so an unaligned first beat lands on the next boundary
      incr_next = (addr & ~(incr - ADDR_WIDTH'(1))) + incr;
      wrap_next = (addr & ~(span - ADDR_WIDTH'(1))) |
                  ((addr + incr) & (span - ADDR_WIDTH'(1)));
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_INCR:  next_addr = incr_next;
         BURST_WRAP:  next_addr = wrap_next;
         default:     next_addr = addr;
      endcase
   end

endmodule

// File: rtl/axi_write_burst_ctrl.sv
// AXI4 write-only slave: turns AW/W bursts into SRAM write cycles through
// an arbitrated memory port.
//   clk, rst           : clock, synchronous active-high reset
//   AW*_i / AWREADY_o  : write address channel
//   W*_i / WREADY_o    : write data channel
//   B*_o / BREADY_i    : write response channel
//   MEM_*_o            : single-port SRAM write port (CEN/WEN active-low)
//   valid_o / grant_i  : request/grant towards the memory arbiter
module axi_write_burst_ctrl
   import axi_mem_if_pkg::*;
#(
   parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
   parameter int unsigned AXI4_WDATA_WIDTH   = 64,
   parameter int unsigned AXI4_ID_WIDTH      = 16,
   parameter int unsigned AXI4_USER_WIDTH    = 10,
   parameter int unsigned AXI_NUMBYTES       = AXI4_WDATA_WIDTH / 8,
   parameter int unsigned MEM_ADDR_WIDTH     = 13
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [AXI4_ID_WIDTH-1:0]      AWID_i,
   input  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_i,
   input  logic [7:0]                    AWLEN_i,
   input  logic [2:0]                    AWSIZE_i,
   input  logic [1:0]                    AWBURST_i,
   input  logic [AXI4_USER_WIDTH-1:0]    AWUSER_i,
   input  logic                          AWVALID_i,
   output logic                          AWREADY_o,
   input  logic [AXI4_WDATA_WIDTH-1:0]   WDATA_i,
   input  logic [AXI_NUMBYTES-1:0]       WSTRB_i,
   input  logic                          WLAST_i,
   input  logic                          WVALID_i,
   output logic                          WREADY_o,
   output logic [AXI4_ID_WIDTH-1:0]      BID_o,
   output logic [1:0]                    BRESP_o,
   output logic [AXI4_USER_WIDTH-1:0]    BUSER_o,
   output logic                          BVALID_o,
   input  logic                          BREADY_i,
   output logic                          MEM_CEN_o,
   output logic                          MEM_WEN_o,
   output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
   output logic [AXI4_WDATA_WIDTH-1:0]   MEM_D_o,
   output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,
   input  logic                          grant_i,
   output logic                          valid_o
);

   localparam int unsigned NB_LOG2 = $clog2(AXI_NUMBYTES);

   wr_state_t                     state_q, state_d;
   logic [AXI4_ID_WIDTH-1:0]      id_q;
   logic [AXI4_USER_WIDTH-1:0]    user_q;
   logic [AXI4_ADDRESS_WIDTH-1:0] addr_q;
   logic [AXI4_ADDRESS_WIDTH-1:0] next_addr;
   logic [7:0]                    len_q;
   logic [7:0]                    cnt_q;
   logic [2:0]                    size_q;
   logic [1:0]                    burst_q;
   resp_t                         resp_q, resp_d;

   logic load_aw;
   logic beat;
   logic aw_err;

   assign aw_err = axi_aw_is_err(AWBURST_i, AWSIZE_i, AWLEN_i, NB_LOG2);

   axi_burst_addr_gen #(
      .ADDR_WIDTH (AXI4_ADDRESS_WIDTH)
   ) u_addr_gen (
      .addr      (addr_q),
      .size      (size_q),
      .len       (len_q),
      .burst     (burst_q),
      .next_addr (next_addr)
   );

   always_comb begin
      state_d   = state_q;
      resp_d    = resp_q;
      load_aw   = 1'b0;
      beat      = 1'b0;
      AWREADY_o = 1'b0;
      WREADY_o  = 1'b0;
      BVALID_o  = 1'b0;
      valid_o   = 1'b0;
      MEM_CEN_o = 1'b1;

      case (state_q)
         ST_IDLE: begin
            AWREADY_o = 1'b1;
            if (AWVALID_i) begin
               load_aw = 1'b1;
               state_d = aw_err ? ST_DRAIN : ST_DATA;
            end
         end
         ST_DATA: begin
            valid_o   = WVALID_i;
            WREADY_o  = grant_i;
            MEM_CEN_o = ~(WVALID_i & grant_i);
            if (WVALID_i && grant_i) begin
               beat = 1'b1;
               if (cnt_q == len_q) begin
                  if (WLAST_i) begin
                     resp_d  = RESP_OKAY;
                     state_d = ST_RESP;
                  end else begin
                     state_d = ST_DRAIN;
                  end
               end else if (WLAST_i) begin
                  // early WLAST: this beat is still written
                  resp_d  = RESP_SLVERR;
                  state_d = ST_RESP;
               end
            end
         end
         ST_DRAIN: begin
            WREADY_o = 1'b1;
            if (WVALID_i && WLAST_i) begin
               resp_d  = RESP_SLVERR;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            BVALID_o  = 1'b1;
            // next AW is only taken alongside the B handshake so one burst
            // is outstanding and the registered B fields stay stable
            AWREADY_o = BREADY_i;
            if (BREADY_i) begin
               if (AWVALID_i) begin
                  load_aw = 1'b1;
                  state_d = aw_err ? ST_DRAIN : ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (rst) begin
         AWREADY_o = 1'b0;
         WREADY_o  = 1'b0;
         BVALID_o  = 1'b0;
         valid_o   = 1'b0;
         MEM_CEN_o = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         id_q    <= '0;
         user_q  <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         resp_q  <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         resp_q  <= resp_d;
         if (load_aw) begin
            id_q    <= AWID_i;
            user_q  <= AWUSER_i;
            addr_q  <= AWADDR_i;
            len_q   <= AWLEN_i;
            size_q  <= AWSIZE_i;
            burst_q <= AWBURST_i;
            cnt_q   <= '0;
         end else if (beat) begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + 8'd1;
         end
      end
   end

   assign BID_o     = id_q;
   assign BUSER_o   = user_q;
   assign BRESP_o   = resp_q;
   assign MEM_WEN_o = 1'b0;
   assign MEM_A_o   = MEM_ADDR_WIDTH'(addr_q >> NB_LOG2);
   assign MEM_D_o   = WDATA_i;
   assign MEM_BE_o  = WSTRB_i;

endmodule

// File: tb/tb_axi_write_burst_ctrl.sv
module tb_axi_write_burst_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [9:0]  awuser;
   logic        awvalid, awready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [15:0] bid;
   logic [1:0]  bresp;
   logic [9:0]  buser;
   logic        bvalid, bready;
   logic        mem_cen, mem_wen;
   logic [12:0] mem_a;
   logic [63:0] mem_d;
   logic [7:0]  mem_be;
   logic        grant, valid;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_write_burst_ctrl #(
      .AXI4_ADDRESS_WIDTH (32),
      .AXI4_WDATA_WIDTH   (64),
      .AXI4_ID_WIDTH      (16),
      .AXI4_USER_WIDTH    (10),
      .AXI_NUMBYTES       (8),
      .MEM_ADDR_WIDTH     (13)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .AWID_i    (awid),
      .AWADDR_i  (awaddr),
      .AWLEN_i   (awlen),
      .AWSIZE_i  (awsize),
      .AWBURST_i (awburst),
      .AWUSER_i  (awuser),
      .AWVALID_i (awvalid),
      .AWREADY_o (awready),
      .WDATA_i   (wdata),
      .WSTRB_i   (wstrb),
      .WLAST_i   (wlast),
      .WVALID_i  (wvalid),
      .WREADY_o  (wready),
      .BID_o     (bid),
      .BRESP_o   (bresp),
      .BUSER_o   (buser),
      .BVALID_o  (bvalid),
      .BREADY_i  (bready),
      .MEM_CEN_o (mem_cen),
      .MEM_WEN_o (mem_wen),
      .MEM_A_o   (mem_a),
      .MEM_D_o   (mem_d),
      .MEM_BE_o  (mem_be),
      .grant_i   (grant),
      .valid_o   (valid)
   );

   typedef struct {
      logic        awv;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [15:0] id;
      logic        wv;
      logic        wl;
      logic [7:0]  strb;
      logic        gnt;
      logic        br;
      logic        e_awr;
      logic        e_wr;
      logic        e_cen;
      logic        e_vld;
      logic [12:0] e_a;
      logic        e_bv;
      logic [1:0]  e_resp;
      logic [15:0] e_bid;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] cur_addr;
   logic [7:0]  cur_len;
   logic [2:0]  cur_size;
   logic [1:0]  cur_burst;
   logic [15:0] cur_id;

   function automatic void set_aw(input logic [31:0] a, input logic [7:0] l,
                                  input logic [2:0] s, input logic [1:0] b,
                                  input logic [15:0] i);
      cur_addr = a; cur_len = l; cur_size = s; cur_burst = b; cur_id = i;
   endfunction

   function automatic void add(input logic awv, input logic wv, input logic wl,
                               input logic [7:0] strb, input logic gnt, input logic br,
                               input logic e_awr, input logic e_wr, input logic e_cen,
                               input logic e_vld, input logic [12:0] e_a,
                               input logic e_bv, input logic [1:0] e_resp);
      vec_t v;
      v.awv = awv; v.addr = cur_addr; v.len = cur_len; v.size = cur_size;
      v.burst = cur_burst; v.id = cur_id; v.wv = wv; v.wl = wl; v.strb = strb;
      v.gnt = gnt; v.br = br; v.e_awr = e_awr; v.e_wr = e_wr; v.e_cen = e_cen;
      v.e_vld = e_vld; v.e_a = e_a; v.e_bv = e_bv; v.e_resp = e_resp; v.e_bid = cur_id;
      vecs.push_back(v);
   endfunction

   function automatic void idle_aw();
      add(1, 0, 0, 8'h00, 0, 0,  1, 0, 1, 0, 13'h0, 0, 2'b00);
   endfunction
   function automatic void wbeat(input logic wl, input logic [7:0] strb, input logic [12:0] a);
      add(0, 1, wl, strb, 1, 0,  0, 1, 0, 1, a, 0, 2'b00);
   endfunction
   function automatic void drain(input logic wl);
      add(0, 1, wl, 8'hFF, 1, 0,  0, 1, 1, 0, 13'h0, 0, 2'b00);
   endfunction
   function automatic void bresp_row(input logic [1:0] r);
      add(0, 0, 0, 8'h00, 0, 1,  1, 0, 1, 0, 13'h0, 1, r);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      awvalid = 0; wvalid = 0; wlast = 0; wstrb = '0; grant = 0; bready = 0;
   endtask

   initial begin
      rst = 1; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
      awuser = '0; wdata = '0;
      idle_inputs();

      // INCR full width
      set_aw(32'h100, 8'd3, 3'd3, 2'b01, 16'h005A);
      idle_aw();
      wbeat(0, 8'hFF, 13'h20); wbeat(0, 8'hFF, 13'h21);
      wbeat(0, 8'hFF, 13'h22); wbeat(1, 8'hFF, 13'h23);
      bresp_row(2'b00);
      // narrow INCR from an unaligned start
      set_aw(32'h104, 8'd2, 3'd2, 2'b01, 16'h0011);
      idle_aw();
      wbeat(0, 8'hF0, 13'h20); wbeat(0, 8'h0F, 13'h21); wbeat(1, 8'hF0, 13'h21);
      bresp_row(2'b00);
      // WRAP over a 32-byte span
      set_aw(32'h118, 8'd3, 3'd3, 2'b10, 16'h0022);
      idle_aw();
      wbeat(0, 8'hFF, 13'h23); wbeat(0, 8'hFF, 13'h20);
      wbeat(0, 8'hFF, 13'h21); wbeat(1, 8'hFF, 13'h22);
      bresp_row(2'b00);
      // FIXED
      set_aw(32'h40, 8'd2, 3'd3, 2'b00, 16'h0023);
      idle_aw();
      wbeat(0, 8'hFF, 13'h08); wbeat(0, 8'hFF, 13'h08); wbeat(1, 8'hFF, 13'h08);
      bresp_row(2'b00);
      // grant stall after beat 1
      set_aw(32'h100, 8'd3, 3'd3, 2'b01, 16'h0033);
      idle_aw();
      wbeat(0, 8'hFF, 13'h20); wbeat(0, 8'hFF, 13'h21);
      add(0, 1, 0, 8'hFF, 0, 0,  0, 0, 1, 1, 13'h0, 0, 2'b00);
      add(0, 1, 0, 8'hFF, 0, 0,  0, 0, 1, 1, 13'h0, 0, 2'b00);
      wbeat(0, 8'hFF, 13'h22); wbeat(1, 8'hFF, 13'h23);
      bresp_row(2'b00);
      // WLAST late: 4 writes, 2 drained
      set_aw(32'h100, 8'd3, 3'd3, 2'b01, 16'h0034);
      idle_aw();
      wbeat(0, 8'hFF, 13'h20); wbeat(0, 8'hFF, 13'h21);
      wbeat(0, 8'hFF, 13'h22); wbeat(0, 8'hFF, 13'h23);
      drain(0); drain(1);
      bresp_row(2'b10);
      // WLAST early on beat 2 of 4
      set_aw(32'h100, 8'd3, 3'd3, 2'b01, 16'h0035);
      idle_aw();
      wbeat(0, 8'hFF, 13'h20); wbeat(1, 8'hFF, 13'h21);
      bresp_row(2'b10);
      // reserved burst type: nothing written
      set_aw(32'h0, 8'd1, 3'd3, 2'b11, 16'h0036);
      idle_aw();
      drain(0); drain(1);
      bresp_row(2'b10);
      // beat wider than the bus
      set_aw(32'h0, 8'd0, 3'd4, 2'b01, 16'h0037);
      idle_aw();
      drain(1);
      bresp_row(2'b10);
      // illegal WRAP length
      set_aw(32'h0, 8'd2, 3'd3, 2'b10, 16'h0038);
      idle_aw();
      drain(1);
      bresp_row(2'b10);

      // reset state
      @(negedge clk); #1;
      chk("rst awready", awready, 0);
      chk("rst bvalid", bvalid, 0);
      chk("rst cen", mem_cen, 1);
      chk("rst valid", valid, 0);
      @(negedge clk); rst = 0; #1;
      chk("post-rst awready", awready, 1);
      chk("post-rst bid", bid, 0);
      chk("post-rst bresp", bresp, 0);
      chk("post-rst buser", buser, 0);
      chk("mem wen", mem_wen, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         awvalid = vecs[i].awv; awaddr = vecs[i].addr; awlen = vecs[i].len;
         awsize = vecs[i].size; awburst = vecs[i].burst; awid = vecs[i].id;
         awuser = vecs[i].id[9:0];
         wvalid = vecs[i].wv; wlast = vecs[i].wl; wstrb = vecs[i].strb;
         wdata = {32'hDEAD_0000, 32'(i)};
         grant = vecs[i].gnt; bready = vecs[i].br;
         #1;
         chk($sformatf("v%0d awready", i), awready, vecs[i].e_awr);
         chk($sformatf("v%0d wready", i), wready, vecs[i].e_wr);
         chk($sformatf("v%0d cen", i), mem_cen, vecs[i].e_cen);
         chk($sformatf("v%0d valid", i), valid, vecs[i].e_vld);
         chk($sformatf("v%0d bvalid", i), bvalid, vecs[i].e_bv);
         if (!vecs[i].e_cen) begin
            chk($sformatf("v%0d mem_a", i), mem_a, vecs[i].e_a);
            chk($sformatf("v%0d mem_be", i), mem_be, vecs[i].strb);
            chk($sformatf("v%0d mem_d", i), mem_d[31:0], i);
         end
         if (vecs[i].e_bv) begin
            chk($sformatf("v%0d bresp", i), bresp, vecs[i].e_resp);
            chk($sformatf("v%0d bid", i), bid, vecs[i].e_bid);
            chk($sformatf("v%0d buser", i), buser, vecs[i].e_bid[9:0]);
         end
      end

      // B back-pressure with the next AW waiting
      @(negedge clk);
      idle_inputs();
      awvalid = 1; awaddr = 32'h0; awlen = 0; awsize = 3; awburst = 2'b01;
      awid = 16'h0044; awuser = 10'h155;
      #1 chk("bp accept awready", awready, 1);
      @(negedge clk);
      awvalid = 0; wvalid = 1; wlast = 1; grant = 1;
      #1 chk("bp beat mem_a", mem_a, 13'h0);
      @(negedge clk);
      wvalid = 0; wlast = 0; grant = 0;
      awvalid = 1; awaddr = 32'h200; awid = 16'h0055; awuser = 10'h0AA;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         chk($sformatf("bp%0d bvalid", c), bvalid, 1);
         chk($sformatf("bp%0d awready", c), awready, 0);
         chk($sformatf("bp%0d bid", c), bid, 16'h0044);
         chk($sformatf("bp%0d buser", c), buser, 10'h155);
         chk($sformatf("bp%0d bresp", c), bresp, 2'b00);
      end
      @(negedge clk);
      bready = 1;
      #1;
      chk("bp release bvalid", bvalid, 1);
      chk("bp release awready", awready, 1);
      @(negedge clk);
      awvalid = 0; bready = 0; wvalid = 1; wlast = 1; grant = 1;
      #1;
      chk("bp next bvalid", bvalid, 0);
      chk("bp next cen", mem_cen, 0);
      chk("bp next mem_a", mem_a, 13'h40);
      @(negedge clk);
      wvalid = 0; wlast = 0; grant = 0; bready = 1;
      #1;
      chk("bp next bid", bid, 16'h0055);
      chk("bp next buser", buser, 10'h0AA);
      chk("bp next bvalid2", bvalid, 1);

      // reset in the middle of a burst
      @(negedge clk);
      idle_inputs();
      awvalid = 1; awaddr = 32'h100; awlen = 3; awsize = 3; awburst = 2'b01; awid = 16'h0066;
      #1 chk("mid accept awready", awready, 1);
      @(negedge clk);
      awvalid = 0; wvalid = 1; grant = 1;
      #1 chk("mid beat mem_a", mem_a, 13'h20);
      @(negedge clk);
      rst = 1;
      #1;
      chk("mid rst wready", wready, 0);
      chk("mid rst cen", mem_cen, 1);
      chk("mid rst valid", valid, 0);
      chk("mid rst awready", awready, 0);
      @(negedge clk);
      rst = 0; wlast = 1;
      #1;
      chk("after rst awready", awready, 1);
      chk("after rst wready", wready, 0);
      chk("after rst cen", mem_cen, 1);
      chk("after rst bvalid", bvalid, 0);
      @(negedge clk);
      idle_inputs();
      #1 chk("after rst bvalid2", bvalid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_write_burst_ctrl.md
Name: axi_write_burst_ctrl

Overview:
AXI4 write-only slave controller that turns AW/W bursts into single-port SRAM write cycles through an arbitrated memory port (grant_i/valid_o).
It is the successor to the single-mode write controller and adds:
- FIXED, INCR and WRAP bursts, including narrow transfers (AWSIZE below the full bus width).
- Protocol errors reported as SLVERR, with recovery instead of a dead-end state.
- Overlap of the B handshake with the next AW acceptance.
It sits between the AXI interconnect and the shared memory arbiter of the dual-port memory interface.

Parameters:
AXI4_ADDRESS_WIDTH, 32, AW address width
AXI4_WDATA_WIDTH, 64, W data and memory data width (power of 2, at least 8)
AXI4_ID_WIDTH, 16, AWID/BID width
AXI4_USER_WIDTH, 10, AWUSER/BUSER width
AXI_NUMBYTES, AXI4_WDATA_WIDTH/8, byte lanes
MEM_ADDR_WIDTH, 13, memory word-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
AWID_i  in  AXI4_ID_WIDTH  write ID
AWADDR_i  in  AXI4_ADDRESS_WIDTH  byte start address
AWLEN_i  in  8  beats minus 1
AWSIZE_i  in  3  log2 of bytes per beat
AWBURST_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWUSER_i  in  AXI4_USER_WIDTH  user sideband
AWVALID_i  in  1  AW valid
AWREADY_o  out  1  AW ready
WDATA_i  in  AXI4_WDATA_WIDTH  write data
WSTRB_i  in  AXI_NUMBYTES  byte strobes
WLAST_i  in  1  last beat
WVALID_i  in  1  W valid
WREADY_o  out  1  W ready
BID_o  out  AXI4_ID_WIDTH  response ID
BRESP_o  out  2  response code
BUSER_o  out  AXI4_USER_WIDTH  response user
BVALID_o  out  1  B valid
BREADY_i  in  1  B ready
MEM_CEN_o  out  1  chip enable, active-low
MEM_WEN_o  out  1  write enable, active-low; tied 0
MEM_A_o  out  MEM_ADDR_WIDTH  word address
MEM_D_o  out  AXI4_WDATA_WIDTH  write data (equals WDATA_i)
MEM_BE_o  out  AXI_NUMBYTES  byte enables (equals WSTRB_i)
grant_i  in  1  arbiter grant
valid_o  out  1  request to arbiter

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; all internal registers clear to 0.
  - BID_o, BUSER_o and BRESP_o registers become 0.
  - While rst is high: AWREADY_o=0, WREADY_o=0, BVALID_o=0, valid_o=0, MEM_CEN_o=1.
  - Reset mid-burst abandons the burst; no B response is issued.
- States: IDLE, DATA, DRAIN, RESP.
- IDLE:
  - AWREADY_o=1.
  - On AW handshake, register ID, USER, byte address, LEN, SIZE and BURST.
  - Classify the request:
    - err=1 if AWBURST=11, if 2^AWSIZE > AXI_NUMBYTES, or if WRAP has LEN not in {1,3,7,15}.
    - err=0 goes to DATA; err=1 goes to DRAIN.
  - There is no combinational AW-to-memory path: the first write occurs at the earliest one cycle after AW acceptance.
- DATA:
  - valid_o=WVALID_i, WREADY_o=grant_i.
  - MEM_CEN_o=~(WVALID_i & grant_i), MEM_A_o = current byte address >> log2(AXI_NUMBYTES).
  - A beat completes when WVALID_i & grant_i; throughput is one beat per cycle.
  - On each beat, the beat count increments and the address advances:
    - FIXED: address is unchanged.
    - INCR: next = (addr aligned down to 2^SIZE) + 2^SIZE, truncated to address width.
    - WRAP: wrap span = (LEN+1)*2^SIZE; next = (addr & ~(span-1)) | ((addr + 2^SIZE) & (span-1)).
  - Beat count equals LEN:
    - WLAST_i=1 goes to RESP with OKAY.
    - WLAST_i=0 goes to DRAIN with the error flag set.
  - Beat count below LEN with WLAST_i=1: the beat is still written, then go to RESP with SLVERR.
- DRAIN:
  - WREADY_o=1, valid_o=0, MEM_CEN_o=1; W beats are discarded.
  - On a W beat with WLAST_i=1, go to RESP with SLVERR.
- RESP:
  - BVALID_o=1, holding the registered BID/BUSER/BRESP stable until BREADY_i.
  - AWREADY_o=BREADY_i, so the next AW can be accepted in the same cycle as the B handshake.
  - B handshake with AW handshake: register the new AW and enter DATA or DRAIN.
  - B handshake without AW: go to IDLE.
- Only one burst is outstanding at a time. WREADY_o=0 in IDLE and RESP.
- Memory data and byte enables pass straight through; the master places narrow data on the correct lanes.

Decomposition:
- Package axi_mem_if_pkg holds:
  - resp_t constants RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR.
  - burst_t constants BURST_FIXED, BURST_INCR, BURST_WRAP.
  - The write-controller state enum.
- Sub-module axi_burst_addr_gen is combinational: (addr, size, len, burst) produces next_addr. It is reused by the future read controller.

Test Plan:
- INCR, AWADDR=0x100, SIZE=3, LEN=3, ID=0x5A, grant_i=1 -> MEM_A_o 0x20,0x21,0x22,0x23 on 4 consecutive cycles; BRESP=OKAY, BID=0x5A.
- Narrow INCR, AWADDR=0x104, SIZE=2, LEN=2 -> MEM_A_o 0x20,0x21,0x21; BE follows WSTRB (0xF0,0x0F,0xF0); OKAY.
- WRAP, AWADDR=0x118, SIZE=3, LEN=3 -> MEM_A_o 0x23,0x20,0x21,0x22; FIXED, AWADDR=0x40, LEN=2 -> 0x08 three times; both OKAY.
- grant_i held low 2 cycles after beat 1 of a LEN=3 burst -> WREADY_o=0 and MEM_CEN_o=1 during the stall; beat 2 then writes 0x22 with no skipped address.
- LEN=3 with WLAST only on the 6th beat -> 4 memory writes, 2 beats drained, BRESP=SLVERR. Separately, AWBURST=11 -> zero writes and SLVERR after WLAST.
- BREADY_i low 3 cycles with AWVALID_i pending -> BVALID_o stays 1 with stable fields and AWREADY_o=0; on BREADY_i=1, B and AW complete in the same cycle.
- rst asserted mid-burst -> next cycle IDLE, no BVALID_o.
